// File: rtl/risc_v_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU codes and datapath mux selects.
package risc_v_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps ALU_OP plus funct fields to the ALU operation.
module alu_decoder
    import risc_v_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op bit 5 set) can encode sub; addi ignores funct7.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencing FSM for the multicycle RISC-V datapath, with a
// retired-instruction counter and halt on unsupported opcodes.
module multicycle_control_unit
    import risc_v_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  OPE_CODE,
    input  logic [2:0]  FUNCT3,
    input  logic        FUNCT7B5,
    input  logic        ZERO,
    output logic        PC_WRITE,
    output logic        ADR_SRC,
    output logic        MEM_WRITE,
    output logic        IR_WRITE,
    output logic        REG_WRITE,
    output logic [1:0]  RESULT_SRC,
    output logic [1:0]  ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic [2:0]  ALU_CONTROL,
    output logic [1:0]  IMM_SRC,
    output logic        HALTED,
    output logic [31:0] INSTRET
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [1:0] w_alu_op;
    logic       w_retire;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = S_HALT;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_alu_op    = ALUOP_ADD;
        ADR_SRC     = 1'b0;
        RESULT_SRC  = RES_ALUOUT;
        ALU_SRC_A   = SRCA_PC;
        ALU_SRC_B   = SRCB_RS2;
        HALTED      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
                ALU_SRC_B   = SRCB_FOUR;
                RESULT_SRC  = RES_ALU;
            end
            S_DECODE: begin
                ALU_SRC_A = SRCA_OLDPC;
                ALU_SRC_B = SRCB_IMM;
                case (OPE_CODE)
                    OP_LW, OP_SW: w_next = S_MEM_ADR;
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEM_ADR: begin
                w_next    = (OPE_CODE == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                ALU_SRC_A = SRCA_RS1;
                ALU_SRC_B = SRCB_IMM;
            end
            S_MEM_READ: begin
                w_next  = S_MEM_WB;
                ADR_SRC = 1'b1;
            end
            S_MEM_WB: begin
                w_next      = S_FETCH;
                RESULT_SRC  = RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEM_WRITE: begin
                w_next      = S_FETCH;
                ADR_SRC     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXEC_R: begin
                w_next    = S_ALU_WB;
                ALU_SRC_A = SRCA_RS1;
                w_alu_op  = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                w_next    = S_ALU_WB;
                ALU_SRC_A = SRCA_RS1;
                ALU_SRC_B = SRCB_IMM;
                w_alu_op  = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                w_next      = S_FETCH;
                w_reg_write = 1'b1;
            end
            S_JAL: begin
                w_next      = S_ALU_WB;
                ALU_SRC_A   = SRCA_OLDPC;
                ALU_SRC_B   = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                w_next    = S_FETCH;
                ALU_SRC_A = SRCA_RS1;
                w_alu_op  = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            default: begin
                w_next = S_HALT;
                HALTED = 1'b1;
            end
        endcase
    end

    // Reset masks every write enable combinationally so a pending instruction
    // cannot touch architectural state during the reset cycle.
    assign PC_WRITE  = ~RST & (w_pc_update | (w_branch & ZERO));
    assign IR_WRITE  = ~RST & w_ir_write;
    assign REG_WRITE = ~RST & w_reg_write;
    assign MEM_WRITE = ~RST & w_mem_write;
    assign IMM_SRC   = imm_src_of(OPE_CODE);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (FUNCT3),
        .i_op5         (OPE_CODE[5]),
        .i_funct7b5    (FUNCT7B5),
        .o_alu_control (ALU_CONTROL)
    );

    assign w_retire = (r_state == S_MEM_WB) || (r_state == S_MEM_WRITE) ||
                      (r_state == S_ALU_WB) || (r_state == S_BEQ);

    always_ff @(posedge CLK) begin
        if (RST)           r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

    assign INSTRET = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues the expected
// output vector for each cycle, a negedge monitor pops and compares it.
module tb_multicycle_control_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  OPE_CODE;
    logic [2:0]  FUNCT3;
    logic        FUNCT7B5;
    logic        ZERO;
    logic        PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, HALTED;
    logic [1:0]  RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
    logic [2:0]  ALU_CONTROL;
    logic [31:0] INSTRET;

    typedef struct packed {
        logic        pcw;
        logic        adr;
        logic        memw;
        logic        irw;
        logic        regw;
        logic [1:0]  res;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [2:0]  alu;
        logic [1:0]  imm;
        logic        halted;
        logic [31:0] n;
    } out_t;

    typedef struct {
        string nm;
        out_t  v;
    } sb_t;

    typedef enum int {F, D, MA, MR, MWB, MW, XR, AWB, XI, J, B, H} tst_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 CLK = ~CLK;

    multicycle_control_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .OPE_CODE    (OPE_CODE),
        .FUNCT3      (FUNCT3),
        .FUNCT7B5    (FUNCT7B5),
        .ZERO        (ZERO),
        .PC_WRITE    (PC_WRITE),
        .ADR_SRC     (ADR_SRC),
        .MEM_WRITE   (MEM_WRITE),
        .IR_WRITE    (IR_WRITE),
        .REG_WRITE   (REG_WRITE),
        .RESULT_SRC  (RESULT_SRC),
        .ALU_SRC_A   (ALU_SRC_A),
        .ALU_SRC_B   (ALU_SRC_B),
        .ALU_CONTROL (ALU_CONTROL),
        .IMM_SRC     (IMM_SRC),
        .HALTED      (HALTED),
        .INSTRET     (INSTRET)
    );

    // Per-state output vectors taken from the state output table.
    function automatic out_t mk(input tst_t s, input logic [2:0] alu, input logic [1:0] imm,
                                input logic z, input logic [31:0] n, input logic rst);
        out_t o;
        o = '0;
        o.alu = alu;
        o.imm = imm;
        o.n   = n;
        case (s)
            F:   begin o.irw = 1'b1; o.pcw = 1'b1; o.sb = 2'b10; o.res = 2'b10; end
            D:   begin o.sa = 2'b01; o.sb = 2'b01; end
            MA:  begin o.sa = 2'b10; o.sb = 2'b01; end
            MR:  begin o.adr = 1'b1; end
            MWB: begin o.res = 2'b01; o.regw = 1'b1; end
            MW:  begin o.adr = 1'b1; o.memw = 1'b1; end
            XR:  begin o.sa = 2'b10; end
            XI:  begin o.sa = 2'b10; o.sb = 2'b01; end
            AWB: begin o.regw = 1'b1; end
            J:   begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; end
            B:   begin o.sa = 2'b10; o.pcw = z; end
            default: begin o.halted = 1'b1; end
        endcase
        if (rst) begin
            o.pcw = 1'b0; o.irw = 1'b0; o.regw = 1'b0; o.memw = 1'b0;
        end
        return o;
    endfunction

    task automatic step(input string nm, input logic rst, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic z, input out_t e);
        sb_t item;
        RST = rst; OPE_CODE = op; FUNCT3 = f3; FUNCT7B5 = f7; ZERO = z;
        item.nm = nm;
        item.v  = e;
        sb_q.push_back(item);
        @(posedge CLK);
        #1;
    endtask

    // One instruction: FETCH, DECODE, then up to three execution states.
    task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic z, input logic [1:0] imm, input int len,
                         input tst_t s2, input logic [2:0] a2, input tst_t s3, input tst_t s4,
                         input logic [31:0] n);
        step({nm, "/F"}, 1'b0, op, f3, f7, z, mk(F,  3'b000, imm, z, n, 1'b0));
        step({nm, "/D"}, 1'b0, op, f3, f7, z, mk(D,  3'b000, imm, z, n, 1'b0));
        step({nm, "/2"}, 1'b0, op, f3, f7, z, mk(s2, a2,     imm, z, n, 1'b0));
        if (len >= 4) step({nm, "/3"}, 1'b0, op, f3, f7, z, mk(s3, 3'b000, imm, z, n, 1'b0));
        if (len >= 5) step({nm, "/4"}, 1'b0, op, f3, f7, z, mk(s4, 3'b000, imm, z, n, 1'b0));
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            sb_t  e;
            out_t a;
            e = sb_q.pop_front();
            a = '{PC_WRITE, ADR_SRC, MEM_WRITE, IR_WRITE, REG_WRITE, RESULT_SRC, ALU_SRC_A,
                  ALU_SRC_B, ALU_CONTROL, IMM_SRC, HALTED, INSTRET};
            n_checks++;
            if (a !== e.v) begin
                n_fail++;
                $display("FAIL %s: got pcw%b adr%b mw%b irw%b rw%b res%b a%b b%b alu%b imm%b h%b n=%h, expected pcw%b adr%b mw%b irw%b rw%b res%b a%b b%b alu%b imm%b h%b n=%h",
                         e.nm, a.pcw, a.adr, a.memw, a.irw, a.regw, a.res, a.sa, a.sb, a.alu,
                         a.imm, a.halted, a.n, e.v.pcw, e.v.adr, e.v.memw, e.v.irw, e.v.regw,
                         e.v.res, e.v.sa, e.v.sb, e.v.alu, e.v.imm, e.v.halted, e.v.n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; OPE_CODE = 7'b1111111; FUNCT3 = 3'b000; FUNCT7B5 = 1'b0; ZERO = 1'b0;
        @(posedge CLK);
        #1;
        step("rst0", 1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, mk(F, 3'b000, 2'b00, 1'b0, 32'd0, 1'b1));
        step("rst1", 1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, mk(F, 3'b000, 2'b00, 1'b0, 32'd0, 1'b1));

        instr("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 5, MA, 3'b000, MR,  MWB, 32'd0);
        instr("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 4, XR, 3'b001, AWB, AWB, 32'd1);
        instr("add",     7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 4, XR, 3'b000, AWB, AWB, 32'd2);
        instr("or",      7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 4, XR, 3'b011, AWB, AWB, 32'd3);
        instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 4, XI, 3'b000, AWB, AWB, 32'd4);
        instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 4, XI, 3'b101, AWB, AWB, 32'd5);
        instr("andi",    7'b0010011, 3'b111, 1'b0, 1'b0, 2'b00, 4, XI, 3'b010, AWB, AWB, 32'd6);
        instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11, 4, J,  3'b000, AWB, AWB, 32'd7);
        instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3, B,  3'b001, F,   F,   32'd8);
        instr("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3, B,  3'b001, F,   F,   32'd9);
        instr("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 4, MA, 3'b000, MW,  MW,  32'd10);

        step("bad/F", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b1, mk(F, 3'b000, 2'b00, 1'b1, 32'd11, 1'b0));
        step("bad/D", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b1, mk(D, 3'b000, 2'b00, 1'b1, 32'd11, 1'b0));
        for (int i = 0; i < 20; i++)
            step("halt", 1'b0, 7'b1111111, 3'b110, 1'b1, 1'b1, mk(H, 3'b000, 2'b00, 1'b1, 32'd11, 1'b0));
        step("halt_rst", 1'b1, 7'b1111111, 3'b000, 1'b0, 1'b1, mk(H, 3'b000, 2'b00, 1'b1, 32'd11, 1'b1));

        // lw abandoned by a reset during its write-back cycle.
        step("mid/F",   1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(F,   3'b000, 2'b00, 1'b0, 32'd0, 1'b0));
        step("mid/D",   1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(D,   3'b000, 2'b00, 1'b0, 32'd0, 1'b0));
        step("mid/MA",  1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(MA,  3'b000, 2'b00, 1'b0, 32'd0, 1'b0));
        step("mid/MR",  1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(MR,  3'b000, 2'b00, 1'b0, 32'd0, 1'b0));
        step("mid/MWB", 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(MWB, 3'b000, 2'b00, 1'b0, 32'd0, 1'b1));

        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        instr("wrap_sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 4, MA, 3'b000, MW, MW, 32'hFFFF_FFFF);
        step("wrap/F", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, mk(F, 3'b000, 2'b00, 1'b0, 32'd0, 1'b0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge CLK);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
